// File: rtl/regfile_mp_if.sv
// Port bundle for regfile_mp: NREAD combinational read ports, one byte-enabled write port,
// and the ready/wr_drop status outputs.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREAD  = 2
);
    logic [NREAD*ADDR_W-1:0] rd_addr;
    logic [NREAD*DATA_W-1:0] rd_data;
    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [DATA_W-1:0]       wr_data;
    logic [DATA_W/8-1:0]     wr_be;
    logic                    ready;
    logic                    wr_drop;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, wr_be,
        input  rd_data, ready, wr_drop
    );
    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, wr_be,
        output rd_data, ready, wr_drop
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with byte-lane writes, optional hardwired zero register and a
// post-reset clear sweep. Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         reset,
    regfile_mp_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_cnt, w_cnt_nxt;
    logic                r_ready, w_ready_nxt;
    logic                r_wr_drop, w_wr_drop_nxt;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic                w_zero_sup;
    logic                w_wr_ok;

    assign w_zero_sup = (ZERO_REG != 0) && (bus.wr_addr == '0);
    assign w_wr_ok    = bus.wr_en && (r_state == RUN) && !w_zero_sup;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= CLEAR;
            r_cnt     <= '0;
            r_ready   <= 1'b0;
            r_wr_drop <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ready   <= w_ready_nxt;
            r_wr_drop <= w_wr_drop_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_ready_nxt   = r_ready;
        w_wr_drop_nxt = 1'b0;
        case (r_state)
            CLEAR: begin
                // Writes arriving mid-sweep are discarded and flagged
                w_wr_drop_nxt = bus.wr_en;
                if (r_cnt == {ADDR_W{1'b1}}) begin
                    w_state_nxt = RUN;
                    w_ready_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            RUN:     w_wr_drop_nxt = 1'b0;
            default: w_state_nxt   = CLEAR;
        endcase
    end

    // Array is left untouched while reset is held; the sweep starts on release
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == CLEAR) begin
                r_mem[r_cnt] <= '0;
            end else if (w_wr_ok) begin
                for (int k = 0; k < NB; k++)
                    if (bus.wr_be[k]) r_mem[bus.wr_addr][8*k +: 8] <= bus.wr_data[8*k +: 8];
            end
        end
    end

    for (genvar p = 0; p < NREAD; p++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_stored;
        logic [DATA_W-1:0] w_val;

        assign w_addr   = bus.rd_addr[p*ADDR_W +: ADDR_W];
        assign w_stored = r_mem[w_addr];
`ifdef REGFILE_BYPASS_EN
        always_comb begin
            w_val = w_stored;
            if (w_wr_ok && (w_addr == bus.wr_addr))
                for (int k = 0; k < NB; k++)
                    if (bus.wr_be[k]) w_val[8*k +: 8] = bus.wr_data[8*k +: 8];
        end
`else
        assign w_val = w_stored;
`endif
        assign bus.rd_data[p*DATA_W +: DATA_W] =
            (!r_ready || ((ZERO_REG != 0) && (w_addr == '0))) ? '0 : w_val;
    end

    assign bus.ready   = r_ready;
    assign bus.wr_drop = r_wr_drop;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed scoreboard bench for regfile_mp (default parameters, either bypass build).
module tb_regfile_mp;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NREAD(2)) bus ();
    regfile_mp dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        string       tag;
        int          sel;   // 0/1 = read port, 2 = ready, 3 = wr_drop
        logic [31:0] exp;
    } chk_t;
    chk_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    function automatic logic [31:0] observe(int sel);
        if (sel == 2) return {31'd0, bus.ready};
        if (sel == 3) return {31'd0, bus.wr_drop};
        return bus.rd_data[sel*32 +: 32];
    endfunction

    task automatic push(string tag, int sel, logic [31:0] exp);
        chk_t c;
        c.tag = tag; c.sel = sel; c.exp = exp;
        q.push_back(c);
    endtask

    task automatic drain();
        chk_t c;
        logic [31:0] obs;
        #1;
        while (q.size() > 0) begin
            c = q.pop_front();
            obs = observe(c.sel);
            n_vec++;
            assert (obs === c.exp) else begin
                n_err++;
                $error("FAIL %s sel=%0d got=%h expected=%h", c.tag, c.sel, obs, c.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(logic [4:0] a, logic [31:0] d, logic [3:0] be);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d; bus.wr_be = be;
    endtask

    task automatic rd(logic [4:0] a0, logic [4:0] a1);
        bus.rd_addr = {a1, a0};
    endtask

    task automatic sweep(string tag);
        for (int e = 1; e <= 32; e++) begin
            tick();
            push(tag, 2, {31'd0, (e == 32)});
            drain();
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_be = '0;
        rd(5'd5, 5'd7);
        wr(5'd5, 32'hDEADBEEF, 4'hF);
        repeat (3) tick();
        push("rst_ready", 2, 0); push("rst_drop", 3, 0);
        push("rst_rd0", 0, 0);   push("rst_rd1", 1, 0);
        drain();

        // Clear sweep with a write held pending the whole time
        reset = 1'b0;
        for (int e = 1; e <= 32; e++) begin
            tick();
            if (e == 32) bus.wr_en = 1'b0;
            push("clr_ready", 2, {31'd0, (e == 32)});
            push("clr_drop", 3, 1);
            if (e < 32) push("clr_rd0", 0, 0);
            drain();
        end
        push("clr_reg5", 0, 0);
        drain();
        tick();
        push("drop_end", 3, 0); push("reg5_run", 0, 0);
        drain();

        // Full-word write
        rd(5'd7, 5'd7);
        wr(5'd7, 32'h12345678, 4'hF);
        push("full_same", 0, BYP ? 32'h12345678 : 32'h0);
        drain();
        tick(); bus.wr_en = 1'b0;
        push("full_p0", 0, 32'h12345678); push("full_p1", 1, 32'h12345678);
        drain();

        // Byte lanes
        wr(5'd7, 32'h000000AB, 4'b0001); tick(); bus.wr_en = 1'b0;
        push("be_low", 0, 32'h123456AB); drain();
        wr(5'd7, 32'hCD000000, 4'b1000); tick(); bus.wr_en = 1'b0;
        push("be_high", 1, 32'hCD3456AB); drain();
        wr(5'd7, 32'hFFFFFFFF, 4'b0000);
        push("be_none_same", 0, 32'hCD3456AB); drain();
        tick(); bus.wr_en = 1'b0;
        push("be_none", 0, 32'hCD3456AB); drain();

        // Zero register
        rd(5'd0, 5'd0);
        wr(5'd0, 32'hFFFFFFFF, 4'hF);
        push("zero_same0", 0, 0); push("zero_same1", 1, 0); drain();
        tick(); bus.wr_en = 1'b0;
        push("zero_next0", 0, 0); push("zero_next1", 1, 0); drain();

        // Same-cycle read/write of one register
        wr(5'd3, 32'h1, 4'hF); tick();
        rd(5'd3, 5'd7);
        wr(5'd3, 32'h2, 4'hF);
        push("rw_same", 0, BYP ? 32'h2 : 32'h1);
        push("rw_other", 1, 32'hCD3456AB);
        drain();
        tick(); bus.wr_en = 1'b0;
        push("rw_next", 0, 32'h2); drain();

        // Reset in RUN, then again mid-sweep
        rd(5'd9, 5'd7);
        wr(5'd9, 32'hA5A5A5A5, 4'hF); tick(); bus.wr_en = 1'b0;
        push("r9_written", 0, 32'hA5A5A5A5); drain();
        reset = 1'b1; tick(); reset = 1'b0;
        push("rr_ready", 2, 0); push("rr_rd0", 0, 0); push("rr_drop", 3, 0); drain();
        repeat (10) tick();
        push("mid_ready", 2, 0); drain();
        reset = 1'b1; tick(); reset = 1'b0;
        sweep("resweep_ready");
        push("r9_cleared", 0, 0); push("r7_cleared", 1, 0); drain();
        rd(5'd3, 5'd3);
        push("r3_cleared", 0, 0); drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
